// File: rtl/vc_input_controller.sv
// Ring-NoC router input port: one DEPTH-deep FIFO per virtual channel. The link
// polarity picks the FIFO written and the FIFO drained; the drained head routes by hop count.
module vc_input_controller #(
  parameter int DATA_W = 64,
  parameter int HOP_W  = 8,
  parameter int DEPTH  = 4,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              polarity,
  input  logic              si,
  output logic              ri,
  input  logic [DATA_W-1:0] di,
  output logic              req_1,
  output logic              req_2,
  input  logic              grant_arbiter_1,
  input  logic              grant_arbiter_2,
  output logic [DATA_W-1:0] output_1,
  output logic [DATA_W-1:0] output_2,
  output logic              err_vc,
  output logic              err_hop,
  output logic [PTR_W:0]    occ_even,
  output logic [PTR_W:0]    occ_odd
);

  localparam int HOP_LSB = DATA_W - 8 - HOP_W;

  // Index 0 is the even VC FIFO, index 1 the odd VC FIFO.
  logic [1:0]        wf_sel;
  logic [1:0]        rf_sel;
  logic [1:0]        fifo_full;
  logic [1:0]        fifo_empty;
  logic [DATA_W-1:0] fifo_head [2];
  logic [PTR_W:0]    fifo_count [2];

  logic              accept;
  logic              vc_ok;
  logic              push_any;
  logic              pop_any;
  logic              drop_hop;
  logic [DATA_W-1:0] rf_head;
  logic              rf_empty;
  logic              wf_full;
  logic [HOP_W-1:0]  head_hop;
  logic              err_vc_reg;
  logic              err_hop_reg;

  assign wf_sel   = {~polarity, polarity};
  assign rf_sel   = {polarity, ~polarity};
  assign rf_head  = polarity ? fifo_head[1] : fifo_head[0];
  assign rf_empty = polarity ? fifo_empty[1] : fifo_empty[0];
  assign wf_full  = polarity ? fifo_full[0] : fifo_full[1];
  assign head_hop = rf_head[HOP_LSB +: HOP_W];

  assign ri       = reset & ~wf_full;
  assign accept   = si & ri;
  assign vc_ok    = (di[DATA_W-1] == ~polarity);
  assign push_any = accept & vc_ok;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fifo
      logic [DATA_W-1:0] mem_reg [DEPTH];
      logic [PTR_W-1:0]  wr_ptr_reg;
      logic [PTR_W-1:0]  rd_ptr_reg;
      logic [PTR_W:0]    count_reg;
      logic              fifo_push;
      logic              fifo_pop;

      assign fifo_push = push_any & wf_sel[gi];
      assign fifo_pop  = pop_any & rf_sel[gi];

      // Storage carries no reset; emptiness is tracked by the pointers alone.
      always_ff @(posedge clk) begin
        if (fifo_push) mem_reg[wr_ptr_reg] <= di;
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else begin
          if (fifo_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
          if (fifo_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
          // A FIFO is never written and drained in the same cycle.
          if (fifo_push)     count_reg <= count_reg + 1'b1;
          else if (fifo_pop) count_reg <= count_reg - 1'b1;
        end
      end

      assign fifo_head[gi]  = mem_reg[rd_ptr_reg];
      assign fifo_count[gi] = count_reg;
      assign fifo_full[gi]  = (count_reg == (PTR_W+1)'(DEPTH));
      assign fifo_empty[gi] = (count_reg == '0);
    end
  endgenerate

  always_comb begin
    req_1    = 1'b0;
    req_2    = 1'b0;
    output_1 = '0;
    output_2 = '0;
    pop_any  = 1'b0;
    drop_hop = 1'b0;
    if (!rf_empty) begin
      if (head_hop == '0) begin
        drop_hop = 1'b1;
        pop_any  = 1'b1;
      end else if (head_hop == HOP_W'(1)) begin
        req_2    = 1'b1;
        output_2 = rf_head;
        output_2[HOP_LSB +: HOP_W] = '0;
        pop_any  = grant_arbiter_2;
      end else begin
        req_1    = 1'b1;
        output_1 = rf_head;
        output_1[HOP_LSB +: HOP_W] = head_hop >> 1;
        pop_any  = grant_arbiter_1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_vc_reg  <= 1'b0;
      err_hop_reg <= 1'b0;
    end else begin
      err_vc_reg  <= accept & ~vc_ok;
      err_hop_reg <= drop_hop;
    end
  end

  assign err_vc   = err_vc_reg;
  assign err_hop  = err_hop_reg;
  assign occ_even = fifo_count[0];
  assign occ_odd  = fifo_count[1];

endmodule

// File: tb/tb_vc_input_controller.sv
// Directed and random stimulus for vc_input_controller, checked against a
// queue-based per-VC reference model with thermometer hop counts.
module tb_vc_input_controller;

  localparam int DATA_W  = 64;
  localparam int HOP_W   = 8;
  localparam int DEPTH   = 4;
  localparam int PTR_W   = 2;
  localparam int HOP_LSB = DATA_W - 8 - HOP_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              polarity;
  logic              si;
  logic              ri;
  logic [DATA_W-1:0] di;
  logic              req_1;
  logic              req_2;
  logic              grant_arbiter_1;
  logic              grant_arbiter_2;
  logic [DATA_W-1:0] output_1;
  logic [DATA_W-1:0] output_2;
  logic              err_vc;
  logic              err_hop;
  logic [PTR_W:0]    occ_even;
  logic [PTR_W:0]    occ_odd;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [DATA_W-1:0] q_even[$];
  logic [DATA_W-1:0] q_odd[$];

  always #5 clk = ~clk;

  vc_input_controller #(.DATA_W(DATA_W), .HOP_W(HOP_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .polarity(polarity), .si(si), .ri(ri), .di(di),
    .req_1(req_1), .req_2(req_2),
    .grant_arbiter_1(grant_arbiter_1), .grant_arbiter_2(grant_arbiter_2),
    .output_1(output_1), .output_2(output_2),
    .err_vc(err_vc), .err_hop(err_hop), .occ_even(occ_even), .occ_odd(occ_odd)
  );

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Packet with a thermometer hop field holding n hops.
  function automatic logic [DATA_W-1:0] with_hops(input logic [DATA_W-1:0] p, input int n);
    logic [DATA_W-1:0] r;
    logic [31:0] therm;
    therm = (32'd1 << n) - 32'd1;
    r = p;
    r[HOP_LSB +: HOP_W] = therm[HOP_W-1:0];
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] mk(input logic vc, input int hops, input logic [31:0] payload);
    logic [DATA_W-1:0] p;
    p = '0;
    p[DATA_W-1] = vc;
    p[DATA_W-2] = payload[0];
    p[31:0]     = payload;
    return with_hops(p, hops);
  endfunction

  // One clock cycle: drive, check combinational outputs, clock, check registered state.
  task automatic step(input logic pol, input logic s, input logic [DATA_W-1:0] d,
                      input logic g1, input logic g2);
    logic              has;
    logic [DATA_W-1:0] head;
    int                wsize;
    int                hc;
    logic              e_ri, e_r1, e_r2, e_evc, e_eh;
    logic [DATA_W-1:0] e_o1, e_o2;
    polarity = pol; si = s; di = d; grant_arbiter_1 = g1; grant_arbiter_2 = g2;
    #2;
    head = '0;
    if (pol) begin
      has = (q_odd.size() > 0);
      if (has) head = q_odd[0];
      wsize = q_even.size();
    end else begin
      has = (q_even.size() > 0);
      if (has) head = q_even[0];
      wsize = q_odd.size();
    end
    hc   = $countones(head[HOP_LSB +: HOP_W]);
    e_ri = (wsize < DEPTH);
    e_r1 = has && (hc > 1);
    e_r2 = has && (hc == 1);
    e_o1 = e_r1 ? with_hops(head, hc - 1) : '0;
    e_o2 = e_r2 ? with_hops(head, 0) : '0;
    chk("ri", DATA_W'(ri), DATA_W'(e_ri));
    chk("req_1", DATA_W'(req_1), DATA_W'(e_r1));
    chk("req_2", DATA_W'(req_2), DATA_W'(e_r2));
    chk("output_1", output_1, e_o1);
    chk("output_2", output_2, e_o2);
    @(posedge clk); #1;
    e_evc = 1'b0;
    e_eh  = 1'b0;
    if (s && e_ri) begin
      if (d[DATA_W-1] == !pol) begin
        if (pol) q_even.push_back(d); else q_odd.push_back(d);
      end else e_evc = 1'b1;
    end
    if (has && (hc == 0 || (hc == 1 && g2) || (hc > 1 && g1))) begin
      if (hc == 0) e_eh = 1'b1;
      if (pol) void'(q_odd.pop_front()); else void'(q_even.pop_front());
    end
    chk("occ_even", DATA_W'(occ_even), DATA_W'(q_even.size()));
    chk("occ_odd", DATA_W'(occ_odd), DATA_W'(q_odd.size()));
    chk("err_vc", DATA_W'(err_vc), DATA_W'(e_evc));
    chk("err_hop", DATA_W'(err_hop), DATA_W'(e_eh));
  endtask

  initial begin
    logic p;
    logic v;
    int   h;
    reset = 1'b1; polarity = 1'b1; si = 1'b1; di = mk(1'b0, 3, 32'h9);
    grant_arbiter_1 = 1'b0; grant_arbiter_2 = 1'b0;
    #1 reset = 1'b0;

    // Reset holds everything quiet even with si asserted.
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("rst_ri", DATA_W'(ri), '0);
      chk("rst_req", DATA_W'({req_1, req_2}), '0);
      chk("rst_out1", output_1, '0);
      chk("rst_out2", output_2, '0);
      chk("rst_occ", DATA_W'({occ_even, occ_odd}), '0);
      chk("rst_err", DATA_W'({err_vc, err_hop}), '0);
    end
    reset = 1'b1; si = 1'b0;
    #1 chk("rel_ri", DATA_W'(ri), DATA_W'(1));

    // Forward path, then eject path with a mismatched grant.
    step(1'b1, 1'b1, mk(1'b0, 3, 32'h1), 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    step(1'b0, 1'b1, mk(1'b1, 1, 32'h2), 1'b0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b1);

    // Fill the even FIFO, then try a fifth write and look at ri on both phases.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, mk(1'b0, 2, 32'h10 + i), 1'b0, 1'b0);
    step(1'b1, 1'b1, mk(1'b0, 2, 32'h14), 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b0);

    // VC mismatch drop, then zero-hop drop.
    step(1'b1, 1'b1, mk(1'b1, 2, 32'h20), 1'b0, 1'b0);
    step(1'b0, 1'b1, mk(1'b1, 0, 32'h21), 1'b0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b1, 1'b1);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);

    // Streaming with alternating phase and grants always on.
    for (int i = 0; i < 12; i++) begin
      p = 1'(i % 2);
      step(p, 1'b1, mk(!p, $urandom_range(1, 3), 32'h100 + i), 1'b1, 1'b1);
    end

    // Random traffic with an asynchronous reset in the middle.
    for (int i = 0; i < 300; i++) begin
      if (i == 150) begin
        reset = 1'b0;
        #2;
        chk("mid_rst_occ_even", DATA_W'(occ_even), '0);
        chk("mid_rst_occ_odd", DATA_W'(occ_odd), '0);
        chk("mid_rst_ri", DATA_W'(ri), '0);
        q_even.delete();
        q_odd.delete();
        @(posedge clk); #1;
        reset = 1'b1;
      end
      p = 1'($urandom_range(0, 1));
      v = ($urandom_range(0, 9) == 0) ? p : !p;
      h = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 5);
      step(p, 1'($urandom_range(0, 1)), mk(v, h, $urandom),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/vc_input_controller.md
Name: vc_input_controller

Overview:
- Parametrised next-generation router input port for the bidirectional ring NoC.
- Replaces single-entry even/odd buffers with one DEPTH-deep FIFO per virtual channel (even VC, odd VC).
- Enforces polarity-based write/read alternation, checks the packet VC bit, and routes each head packet by hop count:
  - hop count > 1: forward to the next-router arbiter, hop field decremented.
  - hop count = 1: eject to the local PE arbiter.

Parameters:
- DATA_W, 64: packet width.
- HOP_W, 8: hop field width; thermometer code (3 hops = 8'b00000111).
- DEPTH, 4: entries per VC FIFO; power of 2, >= 2.
- PTR_W, log2(DEPTH): FIFO pointer width (derived).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- polarity  in  1  link phase; 1 = even-VC write / odd-VC read, 0 = odd-VC write / even-VC read
- si  in  1  upstream send strobe
- ri  out  1  ready to upstream
- di  in  DATA_W  packet: [DATA_W-1] vc, [DATA_W-2] dir, [DATA_W-3 -: 6] reserved, [DATA_W-9 -: HOP_W] hop, remainder source/payload
- req_1  out  1  request to output arbiter 1 (forward)
- req_2  out  1  request to output arbiter 2 (PE eject)
- grant_arbiter_1  in  1  grant from arbiter 1
- grant_arbiter_2  in  1  grant from arbiter 2
- output_1  out  DATA_W  forward packet
- output_2  out  DATA_W  eject packet
- err_vc  out  1  one-cycle pulse: VC-mismatch drop
- err_hop  out  1  one-cycle pulse: zero-hop drop
- occ_even  out  PTR_W+1  even FIFO occupancy
- occ_odd  out  PTR_W+1  odd FIFO occupancy

Behaviour:
- Reset (reset=0, async):
  - Pointers and counts cleared; occ_* = 0.
  - ri, req_1, req_2, err_vc, err_hop, output_1, output_2 all 0.
  - Any in-flight content is discarded.
- Write FIFO (WF) = even if polarity=1, else odd. Read FIFO (RF) = the other FIFO. WF and RF are never the same FIFO in a cycle.
- ri = reset & !full(WF); combinational.
- Accept: si & ri at a rising edge.
  - Packet is pushed into WF only if di[DATA_W-1] == !polarity (even VC = 0, odd VC = 1).
  - On mismatch the packet is dropped: no push, err_vc = 1 for the next cycle.
  - si while ri=0 is ignored; upstream must hold the packet.
- Head routing (combinational from RF head, RF non-empty; hop = head hop field):
  - hop == 0: head is popped at the next edge with no request; err_hop pulses for one cycle.
  - hop == 1 (only LSB set): req_2 = 1; output_2 = head with hop field = 0.
  - hop > 1: req_1 = 1; output_1 = head with hop field >> 1 (one fewer thermometer bit); all other fields unchanged.
  - At most one req per cycle.
  - When not requesting, output_1 and output_2 = 0.
- Pop: req_1 & grant_arbiter_1, or req_2 & grant_arbiter_2, at a rising edge.
  - Zero-latency grant; output data must be sampled by the consumer at that edge.
  - Grant without matching req is ignored. No request on a grant-less cycle is lost; the head is held.
- Latency: a packet written on phase P is eligible on the next opposite-phase cycle. Minimum write-to-request is 1 cycle if polarity toggles.
- Pointers wrap modulo DEPTH.
- Full: ri = 0 for that phase only; the other FIFO still drains.
- Empty RF: no req.
- Simultaneous push (WF) and pop (RF) is always legal, since they are different FIFOs.
- occ_even/occ_odd are registered and update at the edge of each push/pop. Range 0..DEPTH.
- err_vc and err_hop can pulse in the same cycle.
- Reset asserted mid-transfer aborts the transfer. After release, the first accept requires ri=1 at a clean edge.

Test Plan:
- Reset check: hold reset=0 for 2 clocks with si=1 → ri=0, req_*=0, outputs 0, occ_*=0. Release, polarity=1 → ri=1.
- Forward path: polarity=1, si=1, di = vc0, hop 8'b00000111, payload 1 → occ_even=1. Next cycle polarity=0 → req_1=1, output_1 hop=8'b00000011. Assert grant_arbiter_1 → occ_even=0.
- Eject path: polarity=0, di = vc1, hop 8'b00000001, payload 2 → with polarity=1, req_2=1, output_2 hop=0, payload 2. grant_arbiter_2 pops. A grant_arbiter_1-only cycle leaves occ_odd at 1.
- Full/backpressure, DEPTH=4: push 4 even packets with no grants → occ_even=4, ri=0 when polarity=1, ri=1 when polarity=0. A fifth si at polarity=1 is not accepted.
- Errors: polarity=1 with vc bit 1 → no push, err_vc pulse, occ_even unchanged. Head with hop=0 → dropped, err_hop pulse, no req.
- Concurrency and wrap: alternate polarity every cycle for 12 cycles with si=1 and grants always 1 → FIFOs stream with no loss. Pointers wrap past DEPTH. Payload order preserved per VC. Async reset mid-stream clears occ_* immediately.
